// File: rtl/booth_pkg.sv
// -----------------------------------------------------------------------------
// booth_pkg
// Shared types and constants for the sequential radix-2 Booth multiplier.
//   estado_t     : controller states (IDLE, CALC, DONE)
//   N_DEF        : default operand width
//   ancho_cuenta : width of the iteration counter for a given operand width
// -----------------------------------------------------------------------------
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } estado_t;

    localparam int N_DEF = 8;

    // Counter must hold 0 .. n-1; a 1-bit operand still needs one counter bit.
    function automatic int ancho_cuenta(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

    localparam int CUENTA_W = ancho_cuenta(N_DEF);

endpackage

// File: rtl/booth_paso.sv
// -----------------------------------------------------------------------------
// booth_paso
// One purely combinational radix-2 Booth iteration: add/subtract the
// multiplicand according to {q[0], q_1}, then shift {acc, q, q_1} right
// arithmetically by one.
// Ports:
//   acc      in  N+1  accumulator (sign-extended partial product)
//   q        in  N    multiplier / low product bits
//   q_1      in  1    previously shifted-out multiplier bit
//   m        in  N+1  sign-extended multiplicand
//   acc_sig  out N+1  accumulator after the iteration
//   q_sig    out N    multiplier register after the iteration
//   q_1_sig  out 1    q_1 after the iteration
// -----------------------------------------------------------------------------
module booth_paso
    import booth_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic [N:0]   acc,
    input  logic [N-1:0] q,
    input  logic         q_1,
    input  logic [N:0]   m,
    output logic [N:0]   acc_sig,
    output logic [N-1:0] q_sig,
    output logic         q_1_sig
);

    logic [N:0] suma_s;

    // Booth recoding: 01 adds M, 10 subtracts M, 00/11 leave acc alone
    always_comb begin
        suma_s = acc;
        case ({q[0], q_1})
            2'b01:   suma_s = acc + m;
            2'b10:   suma_s = acc - m;
            default: suma_s = acc;
        endcase
    end

    // Arithmetic right shift of the concatenation {acc, q, q_1}
    always_comb begin
        acc_sig = {suma_s[N], suma_s[N:1]};
        q_sig   = {suma_s[0], q[N-1:1]};
        q_1_sig = q[0];
    end

endmodule

// File: rtl/multiplicador_booth.sv
// -----------------------------------------------------------------------------
// multiplicador_booth
// Sequential signed NxN radix-2 Booth multiplier, one iteration per clock.
// A rising edge of pb_salida (held-button level) loads the operands; after N
// iterations the 2N-bit product is registered and listo pulses for one cycle.
// Ports:
//   CLK100MHZ      in  1   100 MHz system clock
//   reset_n        in  1   asynchronous active-low reset
//   multiplicador  in  N   signed multiplier Q
//   multiplicando  in  N   signed multiplicand M
//   pb_salida      in  1   start level; only its rising edge starts work
//   producto       out 2N  registered signed product, held until next result
//   listo          out 1   one-cycle pulse when producto updates
//   ocupado        out 1   high while a multiplication is in progress
// Build option:
//   BOOTH_ZERO_BYPASS_EN  when defined, a zero operand skips the iterations
//                         and the (zero) result appears one cycle after start.
// -----------------------------------------------------------------------------
module multiplicador_booth
    import booth_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic           CLK100MHZ,
    input  logic           reset_n,
    input  logic [N-1:0]   multiplicador,
    input  logic [N-1:0]   multiplicando,
    input  logic           pb_salida,
    output logic [2*N-1:0] producto,
    output logic           listo,
    output logic           ocupado
);

    localparam int CW = ancho_cuenta(N);

    estado_t        estado_r;
    estado_t        estado_sig_s;
    logic           pb_d_r;
    logic           inicio_s;
    logic           bypass_s;

    logic [N:0]     acc_r;
    logic [N-1:0]   q_r;
    logic           q_1_r;
    logic [N:0]     m_r;
    logic [CW-1:0]  cuenta_r;

    logic [N:0]     acc_paso_s;
    logic [N-1:0]   q_paso_s;
    logic           q_1_paso_s;

    logic [2*N-1:0] producto_s;
    logic           listo_s;
    logic           ocupado_s;
    logic [2*N-1:0] producto_r;
    logic           listo_r;
    logic           ocupado_r;

    // Delayed copy of the start level for rising-edge detection
    always_ff @(posedge CLK100MHZ or negedge reset_n) begin
        if (!reset_n) begin
            pb_d_r <= 1'b0;
        end else begin
            pb_d_r <= pb_salida;
        end
    end

    assign inicio_s = pb_salida & ~pb_d_r;

`ifdef BOOTH_ZERO_BYPASS_EN
    assign bypass_s = (multiplicador == {N{1'b0}}) || (multiplicando == {N{1'b0}});
`else
    assign bypass_s = 1'b0;
`endif

    booth_paso #(.N(N)) u_paso (
        .acc     (acc_r),
        .q       (q_r),
        .q_1     (q_1_r),
        .m       (m_r),
        .acc_sig (acc_paso_s),
        .q_sig   (q_paso_s),
        .q_1_sig (q_1_paso_s)
    );

    // Controller state register
    always_ff @(posedge CLK100MHZ or negedge reset_n) begin
        if (!reset_n) begin
            estado_r <= IDLE;
        end else begin
            estado_r <= estado_sig_s;
        end
    end

    // Next-state logic; starts arriving outside IDLE are simply dropped
    always_comb begin
        estado_sig_s = estado_r;
        case (estado_r)
            IDLE: begin
                if (inicio_s) begin
                    if (bypass_s) begin
                        estado_sig_s = DONE;
                    end else begin
                        estado_sig_s = CALC;
                    end
                end else begin
                    estado_sig_s = IDLE;
                end
            end
            CALC: begin
                // The iteration running with cuenta = N-1 is the last one
                if (cuenta_r == CW'(N - 1)) begin
                    estado_sig_s = DONE;
                end else begin
                    estado_sig_s = CALC;
                end
            end
            DONE:    estado_sig_s = IDLE;
            default: estado_sig_s = IDLE;
        endcase
    end

    // Datapath: operand capture on start, one Booth step per CALC cycle
    always_ff @(posedge CLK100MHZ or negedge reset_n) begin
        if (!reset_n) begin
            acc_r    <= {(N+1){1'b0}};
            q_r      <= {N{1'b0}};
            q_1_r    <= 1'b0;
            m_r      <= {(N+1){1'b0}};
            cuenta_r <= {CW{1'b0}};
        end else begin
            case (estado_r)
                IDLE: begin
                    if (inicio_s) begin
                        acc_r    <= {(N+1){1'b0}};
                        // Bypassed runs read {acc, q} directly, so clear q to force zero
                        q_r      <= bypass_s ? {N{1'b0}} : multiplicador;
                        q_1_r    <= 1'b0;
                        m_r      <= {multiplicando[N-1], multiplicando};
                        cuenta_r <= {CW{1'b0}};
                    end else begin
                        acc_r    <= acc_r;
                        q_r      <= q_r;
                        q_1_r    <= q_1_r;
                        m_r      <= m_r;
                        cuenta_r <= cuenta_r;
                    end
                end
                CALC: begin
                    acc_r    <= acc_paso_s;
                    q_r      <= q_paso_s;
                    q_1_r    <= q_1_paso_s;
                    cuenta_r <= cuenta_r + CW'(1);
                end
                default: begin
                    acc_r    <= acc_r;
                    q_r      <= q_r;
                    q_1_r    <= q_1_r;
                    m_r      <= m_r;
                    cuenta_r <= cuenta_r;
                end
            endcase
        end
    end

    // Output decode from the current state; registered below
    always_comb begin
        producto_s = producto_r;
        listo_s    = 1'b0;
        ocupado_s  = (estado_r != IDLE);
        if (estado_r == DONE) begin
            producto_s = {acc_r[N-1:0], q_r};
            listo_s    = 1'b1;
        end else begin
            producto_s = producto_r;
            listo_s    = 1'b0;
        end
    end

    // Output registers
    always_ff @(posedge CLK100MHZ or negedge reset_n) begin
        if (!reset_n) begin
            producto_r <= {(2*N){1'b0}};
            listo_r    <= 1'b0;
            ocupado_r  <= 1'b0;
        end else begin
            producto_r <= producto_s;
            listo_r    <= listo_s;
            ocupado_r  <= ocupado_s;
        end
    end

    assign producto = producto_r;
    assign listo    = listo_r;
    assign ocupado  = ocupado_r;

endmodule

// File: tb/tb_multiplicador_booth.sv
// -----------------------------------------------------------------------------
// tb_multiplicador_booth
// Directed bench for multiplicador_booth. A cycle-level reference model
// (start-edge detection, fixed latency, plain signed multiply) predicts
// listo/ocupado/producto after every clock edge; a compare process checks
// them on every falling edge. Directed runs also check literal products and
// measured latencies.
// -----------------------------------------------------------------------------
module tb_multiplicador_booth;

    localparam int N = 8;

`ifdef BOOTH_ZERO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic           CLK100MHZ     = 1'b0;
    logic           reset_n       = 1'b1;
    logic [N-1:0]   multiplicador = 8'h00;
    logic [N-1:0]   multiplicando = 8'h00;
    logic           pb_salida     = 1'b0;
    logic [2*N-1:0] producto;
    logic           listo;
    logic           ocupado;

    int tests = 0;
    int fails = 0;
    bit chk_on = 1'b0;

    multiplicador_booth #(.N(N)) dut (
        .CLK100MHZ     (CLK100MHZ),
        .reset_n       (reset_n),
        .multiplicador (multiplicador),
        .multiplicando (multiplicando),
        .pb_salida     (pb_salida),
        .producto      (producto),
        .listo         (listo),
        .ocupado       (ocupado)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: expected outputs after each rising edge
    int          rem     = 0;
    logic        pb_prev = 1'b0;
    logic        m_listo = 1'b0;
    logic        m_ocup  = 1'b0;
    logic [15:0] m_prod  = 16'h0000;
    logic [15:0] pend    = 16'h0000;

    always @(posedge CLK100MHZ or negedge reset_n) begin : modelo
        bit busy;
        if (!reset_n) begin
            rem = 0; pb_prev = 1'b0; m_listo = 1'b0; m_ocup = 1'b0;
            m_prod = 16'h0000; pend = 16'h0000;
        end else begin
            busy    = (rem > 0);
            m_listo = 1'b0;
            m_ocup  = busy;
            if (busy) begin
                rem--;
                if (rem == 0) begin
                    m_listo = 1'b1;
                    m_prod  = pend;
                end
            end else if (pb_salida && !pb_prev) begin
                pend = $signed(multiplicador) * $signed(multiplicando);
                rem  = (BYP && (multiplicador == 8'h00 || multiplicando == 8'h00)) ? 1 : N + 1;
            end
            pb_prev = pb_salida;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge CLK100MHZ) begin
        if (chk_on) begin
            chk("listo", {15'h0000, listo}, {15'h0000, m_listo});
            chk("ocupado", {15'h0000, ocupado}, {15'h0000, m_ocup});
            chk("producto", producto, m_prod);
        end
    end

    // One start pulse; operands are scrambled after load to prove they are latched
    task automatic run(input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] lit, input int lat);
        int k;
        bit seen;
        @(negedge CLK100MHZ);
        multiplicador = a; multiplicando = b; pb_salida = 1'b1;
        @(negedge CLK100MHZ);
        multiplicador = ~a; multiplicando = b ^ 8'h5A;
        k = 1; seen = 1'b0;
        while (!seen && k < 40) begin
            if (listo) begin
                seen = 1'b1;
            end else begin
                @(negedge CLK100MHZ);
                k++;
            end
        end
        chk("listo_timeout", {15'h0000, seen}, 16'h0001);
        chk("latencia", 16'(k - 1), 16'(lat));
        chk("producto_lit", producto, lit);
        pb_salida = 1'b0;
        repeat (3) @(negedge CLK100MHZ);
    endtask

    initial begin : estimulo
        int cnt;
        #2 reset_n = 1'b0;
        #1 chk_on = 1'b1;
        @(negedge CLK100MHZ);
        chk("reset_producto", producto, 16'h0000);
        chk("reset_listo", {15'h0000, listo}, 16'h0000);
        chk("reset_ocupado", {15'h0000, ocupado}, 16'h0000);
        @(negedge CLK100MHZ);
        #2 reset_n = 1'b1;

        run(8'd3,  8'd5,  16'h000F, 9);
        run(8'hFD, 8'd5,  16'hFFF1, 9);
        run(8'h7F, 8'h80, 16'hC080, 9);
        run(8'h80, 8'h80, 16'h4000, 9);
        run(8'h05, 8'hFD, 16'hFFF1, 9);

        // Level held for 50 cycles gives exactly one result
        @(negedge CLK100MHZ);
        multiplicador = 8'd3; multiplicando = 8'd5; pb_salida = 1'b1;
        cnt = 0;
        repeat (50) begin
            @(negedge CLK100MHZ);
            if (listo) cnt++;
        end
        chk("pulsos_mantenido", 16'(cnt), 16'd1);
        pb_salida = 1'b0;
        repeat (3) @(negedge CLK100MHZ);

        // Second rise during CALC is ignored
        multiplicador = 8'd6; multiplicando = 8'd7; pb_salida = 1'b1;
        cnt = 0;
        @(negedge CLK100MHZ);
        @(negedge CLK100MHZ);
        pb_salida = 1'b0;
        @(negedge CLK100MHZ);
        pb_salida = 1'b1;
        repeat (25) begin
            @(negedge CLK100MHZ);
            if (listo) cnt++;
        end
        chk("pulsos_re_subida", 16'(cnt), 16'd1);
        chk("producto_6x7", producto, 16'h002A);
        pb_salida = 1'b0;
        repeat (2) @(negedge CLK100MHZ);

        // A rise after DONE starts a fresh run
        run(8'hF6, 8'd10, 16'hFF9C, 9);

        // Reset in the middle of CALC aborts without a listo pulse
        @(negedge CLK100MHZ);
        multiplicador = 8'd9; multiplicando = 8'hF9; pb_salida = 1'b1;
        @(negedge CLK100MHZ);
        pb_salida = 1'b0;
        repeat (3) @(negedge CLK100MHZ);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_producto", producto, 16'h0000);
        chk("abort_listo", {15'h0000, listo}, 16'h0000);
        chk("abort_ocupado", {15'h0000, ocupado}, 16'h0000);
        cnt = 0;
        repeat (12) begin
            @(negedge CLK100MHZ);
            if (listo) cnt++;
        end
        chk("abort_sin_listo", 16'(cnt), 16'd0);
        #2 reset_n = 1'b1;
        run(8'd2, 8'hFF, 16'hFFFE, 9);

        // Zero operand: latency depends on the bypass option
        run(8'd0, 8'd77, 16'h0000, BYP ? 1 : 9);
        run(8'd77, 8'd0, 16'h0000, BYP ? 1 : 9);

        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
